// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC generation, req/gnt/rvalid memory reads, and a small
// instruction buffer presenting {instr, pc, pc+4} to decode.
module instr_fetch_unit #(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int unsigned        FIFO_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic [ADDR_W-1:0] pc_plus4_o,
  input  logic              instr_ready_i
);

  localparam int unsigned     PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned     CntW  = PtrW + 2;
  localparam logic [CntW-1:0] Depth = CntW'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CntW-1:0]   outst_q, outst_d;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       data_mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [FIFO_DEPTH];

  logic              pop, grant, rsp, push;
  logic [ADDR_W-1:0] redirect_pc;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc_i[1:0];
  assign redirect_pc    = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  assign instr_valid_o = (count_q != '0);
  assign pop           = instr_valid_o & instr_ready_i;

  // A slot freed by this cycle's pop can already be claimed by a new request.
  assign imem_req_o  = ~rst_i & ((outst_q + count_q - CntW'(pop)) < Depth);
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o & imem_gnt_i;
  assign rsp         = imem_rvalid_i & (outst_q != '0);
  assign push        = rsp & (drop_q == '0) & ~redirect_i;

  assign instr_o    = instr_valid_o ? data_mem_q[rd_ptr_q] : '0;
  assign instr_pc_o = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign pc_plus4_o = instr_valid_o ? pc_mem_q[rd_ptr_q] + ADDR_W'(4) : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    outst_d    = outst_q + CntW'(grant) - CntW'(rsp);
    count_d    = count_q + CntW'(push) - CntW'(pop);

    if (grant) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (rsp && (drop_q != '0)) drop_d = drop_q - CntW'(1);
    if (push) begin
      wr_ptr_d  = wr_ptr_q + PtrW'(1);
      resp_pc_d = resp_pc_q + ADDR_W'(4);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);

    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_i) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = outst_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i) !(imem_rvalid_i && (outst_q == '0)));
  assert property (@(posedge clk_i) disable iff (rst_i) push |-> (count_q < Depth));
  assert property (@(posedge clk_i) disable iff (rst_i) (outst_q + count_q) <= Depth);
  assert property (@(posedge clk_i) disable iff (rst_i) drop_q <= outst_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a variable-latency in-order memory
// that returns addr/4 as data.
module tb_instr_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] pc_plus4_o;
  logic        instr_ready_i;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int lat = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;
  mem_req_t mem_q[$];

  always #5 clk_i = ~clk_i;

  instr_fetch_unit dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .pc_plus4_o    (pc_plus4_o),
    .instr_ready_i (instr_ready_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples the memory interface mid-cycle, advances one clock, updates the memory.
  task automatic tick();
    logic        req_s, gnt_s, rv_s, rst_s;
    logic [31:0] addr_s;
    #4;
    req_s  = imem_req_o;
    gnt_s  = imem_gnt_i;
    rv_s   = imem_rvalid_i;
    rst_s  = rst_i;
    addr_s = imem_addr_o;
    @(posedge clk_i);
    #1;
    edge_cnt++;
    if (rst_s) begin
      mem_q.delete();
    end else begin
      if (rv_s && mem_q.size() > 0) mem_q.delete(0);
      if (req_s && gnt_s) mem_q.push_back('{addr: addr_s, due: edge_cnt + lat});
    end
    imem_rvalid_i = (mem_q.size() > 0) && (mem_q[0].due <= edge_cnt + 1);
    imem_rdata_i  = imem_rvalid_i ? (mem_q[0].addr >> 2) : 32'h0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid_o) break;
      tick();
    end
    check_eq({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc);
    check_eq({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd1);
    check_eq({tag, "_pc"}, instr_pc_o, pc);
    check_eq({tag, "_instr"}, instr_o, pc >> 2);
    check_eq({tag, "_pc4"}, pc_plus4_o, pc + 32'd4);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
    check_eq({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
    check_eq({tag, "_instr"}, instr_o, 32'd0);
    check_eq({tag, "_pc"}, instr_pc_o, 32'd0);
    check_eq({tag, "_pc4"}, pc_plus4_o, 32'd0);
  endtask

  initial begin
    rst_i         = 1'b1;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b1;

    // Reset state and first-fetch latency
    tick();
    tick();
    check_zero("rst");
    rst_i = 1'b0;
    #1;
    check_eq("c1_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("c1_addr", imem_addr_o, 32'h0);
    tick();
    check_eq("c2_valid", {31'b0, instr_valid_o}, 32'd0);
    check_eq("c2_addr", imem_addr_o, 32'h4);
    tick();
    check_head("c3", 32'h0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_head("stream", 32'(4 * i));
    end

    // Decode stall: buffer fills, requests stop, order preserved on release
    instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_pc", instr_pc_o, 32'h14);
    end
    check_eq("stall_req", {31'b0, imem_req_o}, 32'd0);
    instr_ready_i = 1'b1;
    #1;
    check_eq("unstall_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("unstall_addr", imem_addr_o, 32'h1C);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_head("unstall", 32'h14 + 32'(4 * i));
    end

    // Latency 3: two stale requests in flight when redirecting to 0x40
    lat = 3;
    tick();
    tick();
    check_eq("lat3_valid", {31'b0, instr_valid_o}, 32'd0);
    check_eq("lat3_req", {31'b0, imem_req_o}, 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    wait_valid("rd40");
    check_head("rd40", 32'h40);
    tick();
    wait_valid("rd44");
    check_head("rd44", 32'h44);

    // Redirect coinciding with rvalid and gnt, unaligned target
    lat = 1;
    for (int i = 0; i < 8; i++) tick();
    check_eq("pre_rd_valid", {31'b0, instr_valid_o}, 32'd1);
    check_eq("pre_rd_req", {31'b0, imem_req_o}, 32'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h103;
    tick();
    redirect_i = 1'b0;
    wait_valid("rd100");
    check_head("rd100", 32'h100);
    tick();
    check_head("rd104", 32'h104);

    // Grant withheld: request and address hold, buffer drains
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("nognt_req", {31'b0, imem_req_o}, 32'd1);
      check_eq("nognt_addr", imem_addr_o, 32'h10C);
      tick();
    end
    check_eq("nognt_valid", {31'b0, instr_valid_o}, 32'd0);
    imem_gnt_i = 1'b1;
    wait_valid("gnt10c");
    check_head("gnt10c", 32'h10C);
    tick();
    check_head("gnt110", 32'h110);

    // Fill buffer, then leave two requests in flight and reset
    instr_ready_i = 1'b0;
    lat = 3;
    tick();
    check_head("full", 32'h110);
    check_eq("full_req", {31'b0, imem_req_o}, 32'd0);
    instr_ready_i = 1'b1;
    tick();
    tick();
    check_eq("inflight_valid", {31'b0, instr_valid_o}, 32'd0);
    rst_i = 1'b1;
    tick();
    check_zero("midrst");
    rst_i = 1'b0;
    lat   = 1;
    #1;
    check_eq("rst_req", {31'b0, imem_req_o}, 32'd1);
    check_eq("rst_addr", imem_addr_o, 32'h0);
    wait_valid("rst0");
    check_head("rst0", 32'h0);
    tick();
    check_head("rst4", 32'h4);

    // Address wrap at the top of the space
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFE;
    tick();
    redirect_i = 1'b0;
    wait_valid("top");
    check_eq("top_pc", instr_pc_o, 32'hFFFF_FFFC);
    check_eq("top_instr", instr_o, 32'h3FFF_FFFF);
    check_eq("top_pc4", pc_plus4_o, 32'h0);
    tick();
    wait_valid("wrap");
    check_head("wrap", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
